// File: rtl/keypress_event_queue_pkg.sv
// Shared defaults for the keypress event queue.
// Events are packed {keycode, timestamp} with the keycode in the MSBs.
package keypress_event_queue_pkg;

    localparam int KEV_DEPTH    = 8;
    localparam int KEV_KC_WIDTH = 5;
    localparam int KEV_TS_WIDTH = 16;

    localparam logic [1:0] OCC_HOLD = 2'b00;
    localparam logic [1:0] OCC_INC  = 2'b01;
    localparam logic [1:0] OCC_DEC  = 2'b10;

    // Classify a cycle's effect on occupancy from accepted push/pop.
    function automatic logic [1:0] occ_step(input logic push, input logic pop);
        logic [1:0] r;
        r = OCC_HOLD;
        if (push && !pop) begin
            r = OCC_INC;
        end else if (!push && pop) begin
            r = OCC_DEC;
        end
        return r;
    endfunction

endpackage

// File: rtl/keypress_event_queue_sync.sv
// Two-flop synchronizer plus an edge flop; yields the synced level
// and a one-cycle pulse on its rising edge.
module sync_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~s3_q;

endmodule

// File: rtl/keypress_event_queue.sv
// Converts keypad presses into timestamped events held in a small FIFO,
// and keeps the free-running millisecond counter.
module keypress_event_queue
    import keypress_event_queue_pkg::*;
#(
    parameter int DEPTH    = KEV_DEPTH,
    parameter int KC_WIDTH = KEV_KC_WIDTH,
    parameter int TS_WIDTH = KEV_TS_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ready,
    input  logic [KC_WIDTH-1:0]        keycode,
    input  logic                       clk_1ms,
    input  logic                       pop,
    input  logic                       clr_ovf,
    output logic                       ev_valid,
    output logic [KC_WIDTH-1:0]        ev_keycode,
    output logic [TS_WIDTH-1:0]        ev_time,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [TS_WIDTH-1:0]        now_ms
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = KC_WIDTH + TS_WIDTH;

    logic                rdy_lvl;
    logic                push_req;
    logic                tick_lvl;
    logic                tick;
    logic                unused_lvl;

    logic [KC_WIDTH-1:0] kc_s1_q;
    logic [KC_WIDTH-1:0] kc_s2_q;

    logic [TS_WIDTH-1:0] now_q;
    logic [TS_WIDTH-1:0] now_d;

    logic [EW-1:0]       mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q;
    logic [PW-1:0]       wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q;
    logic [PW-1:0]       rd_ptr_d;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_d;
    logic                ovf_q;
    logic                ovf_d;

    logic                empty;
    logic                full;
    logic                do_pop;
    logic                do_push;
    logic                drop;
    logic [EW-1:0]       ev_in;
    logic [EW-1:0]       head;

    sync_rise_detect u_sync_ready (
        .clk     (clk),
        .rst     (rst),
        .d_i     (ready),
        .level_o (rdy_lvl),
        .rise_o  (push_req)
    );

    sync_rise_detect u_sync_tick (
        .clk     (clk),
        .rst     (rst),
        .d_i     (clk_1ms),
        .level_o (tick_lvl),
        .rise_o  (tick)
    );

    assign unused_lvl = rdy_lvl ^ tick_lvl;

    // Keycode follows ready through the same two stages so the
    // code captured on the synced edge is the one sent with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kc_s1_q <= '0;
            kc_s2_q <= '0;
        end else begin
            kc_s1_q <= keycode;
            kc_s2_q <= kc_s1_q;
        end
    end

    always_comb begin
        now_d = now_q;
        if (tick) begin
            now_d = now_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            now_q <= '0;
        end else begin
            now_q <= now_d;
        end
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push_req & (~full | do_pop);
    assign drop    = push_req & full & ~do_pop;
    assign ev_in   = {kc_s2_q, now_q};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case (occ_step(do_push, do_pop))
            OCC_INC: count_d = count_q + 1'b1;
            OCC_DEC: count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        // A drop in the same cycle as a clear must still be reported.
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= ev_in;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign ev_valid   = ~empty;
    assign ev_keycode = head[EW-1:TS_WIDTH];
    assign ev_time    = head[TS_WIDTH-1:0];
    assign count      = count_q;
    assign overflow   = ovf_q;
    assign now_ms     = now_q;

endmodule
